// File: rtl/bcd_display_driver.sv
// Stability-filtered BCD latch driving a multiplexed, active-low seven-segment display.
// The filter hides transient converter output; the scanner walks one digit per slot.
module bcd_display_driver #(
    parameter int DECIMAL_DIGITS = 2,
    parameter int STABLE_CYCLES  = 16,
    parameter int SCAN_CYCLES    = 25000
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
    input  logic                          i_Blank_Zeros,
    output logic [6:0]                    o_Segment,
    output logic [DECIMAL_DIGITS-1:0]     o_Digit_En,
    output logic                          o_Updated
);

    localparam int BW = DECIMAL_DIGITS * 4;
    localparam int NW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int KW = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;

    localparam logic [NW-1:0] N_MAX  = NW'(STABLE_CYCLES);
    localparam logic [NW-1:0] N_LAST = NW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [KW-1:0] K_LAST = KW'(DECIMAL_DIGITS - 1);

    logic [BW-1:0]             cand_q, cand_d;
    logic [BW-1:0]             disp_q, disp_d;
    logic [NW-1:0]             cnt_q, cnt_d;
    logic                      upd_q, upd_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic [KW-1:0]             dig_q, dig_d;
    logic [6:0]                seg_q, seg_d;
    logic [DECIMAL_DIGITS-1:0] en_q, en_d;

    logic [3:0] cur_digit;
    logic       upper_nz;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111110;
        endcase
    endfunction

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        disp_d = disp_q;
        upd_d  = 1'b0;
        // Any change restarts the window; the counter parks at N_MAX once settled.
        if (i_BCD != cand_q) begin
            cand_d = i_BCD;
            cnt_d  = '0;
        end else if (cnt_q < N_MAX) begin
            cnt_d = cnt_q + NW'(1);
            if (cnt_q == N_LAST && cand_q != disp_q) begin
                disp_d = cand_q;
                upd_d  = 1'b1;
            end
        end

        slot_d = (slot_q == S_LAST) ? '0 : slot_q + SW'(1);
        dig_d  = dig_q;
        if (slot_q == S_LAST)
            dig_d = (dig_q == K_LAST) ? '0 : dig_q + KW'(1);

        // upper_nz: some digit at or above the active one is non-zero.
        cur_digit = 4'd0;
        upper_nz  = 1'b0;
        for (int j = 0; j < DECIMAL_DIGITS; j++) begin
            if (dig_q == KW'(j))
                cur_digit = disp_q[4*j +: 4];
            if (KW'(j) >= dig_q && disp_q[4*j +: 4] != 4'd0)
                upper_nz = 1'b1;
        end

        if (i_Blank_Zeros && dig_q != '0 && !upper_nz)
            seg_d = 7'b1111111;
        else
            seg_d = seg_decode(cur_digit);
        en_d = ~(DECIMAL_DIGITS'(1) << dig_q);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cand_q <= '0;
            disp_q <= '0;
            cnt_q  <= '0;
            upd_q  <= 1'b0;
            slot_q <= '0;
            dig_q  <= '0;
            seg_q  <= 7'b1111111;
            en_q   <= '1;
        end else begin
            cand_q <= cand_d;
            disp_q <= disp_d;
            cnt_q  <= cnt_d;
            upd_q  <= upd_d;
            slot_q <= slot_d;
            dig_q  <= dig_d;
            seg_q  <= seg_d;
            en_q   <= en_d;
        end
    end

    assign o_Segment  = seg_q;
    assign o_Digit_En = en_q;
    assign o_Updated  = upd_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: 2 digits, 4-cycle filter, 8-cycle scan slots.
module tb_bcd_display_driver;

    localparam int DD = 2;
    localparam int ST = 4;
    localparam int SC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  bcd = 8'h00;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic [1:0]  en;
    logic        upd;

    int n_chk = 0;
    int n_pass = 0;

    bcd_display_driver #(
        .DECIMAL_DIGITS(DD),
        .STABLE_CYCLES (ST),
        .SCAN_CYCLES   (SC)
    ) dut (
        .i_Clock      (clk),
        .i_Rst_L      (rst_n),
        .i_BCD        (bcd),
        .i_Blank_Zeros(blank),
        .o_Segment    (seg),
        .o_Digit_En   (en),
        .o_Updated    (upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bcd;
        logic       blank;
        logic [6:0] s0;
        logic [6:0] s1;
        int         pulses;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[12];
        int   pulses;
        int   bad_en;
        logic [7:0] s0, s1;

        tbl[0]  = '{8'h57, 1'b0, 7'b0001111, 7'b0100100, 1};
        tbl[1]  = '{8'h05, 1'b1, 7'b0100100, 7'b1111111, 1};
        tbl[2]  = '{8'h05, 1'b0, 7'b0100100, 7'b0000001, 0};
        tbl[3]  = '{8'hA3, 1'b0, 7'b0000110, 7'b1111110, 1};
        tbl[4]  = '{8'h00, 1'b1, 7'b0000001, 7'b1111111, 1};
        tbl[5]  = '{8'h00, 1'b0, 7'b0000001, 7'b0000001, 0};
        tbl[6]  = '{8'h80, 1'b1, 7'b0000001, 7'b0000000, 1};
        tbl[7]  = '{8'h61, 1'b0, 7'b1001111, 7'b0100000, 1};
        tbl[8]  = '{8'h32, 1'b1, 7'b0010010, 7'b0000110, 1};
        tbl[9]  = '{8'h4F, 1'b1, 7'b1111110, 7'b1001100, 1};
        tbl[10] = '{8'h09, 1'b1, 7'b0000100, 7'b1111111, 1};
        tbl[11] = '{8'h98, 1'b0, 7'b0000000, 7'b0000100, 1};

        // Reset state, observed without a clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_en", 32'(en), 32'h3);
        chk("rst_upd", 32'(upd), 32'h0);

        // Scan cadence with input 0: digit0 for 8 cycles then digit1 for 8
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (upd) pulses++;
            if (k == 1) begin
                chk("first_en", 32'(en), 32'h2);
                chk("first_seg", 32'(seg), 32'h01);
            end
            if (k == 8)  chk("en_c8", 32'(en), 32'h2);
            if (k == 9)  chk("en_c9", 32'(en), 32'h1);
            if (k == 9)  chk("seg_d1_zero", 32'(seg), 32'h01);
            if (k == 16) chk("en_c16", 32'(en), 32'h1);
            if (k == 17) chk("en_c17", 32'(en), 32'h2);
        end
        chk("no_pulse_zero", 32'(pulses), 32'd0);

        // Commit latency: pulse exactly on the 4th edge after the first sample
        bcd = 8'h57;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 4) chk("lat_e3_upd", 32'(upd), 32'h0);
            if (k == 5) chk("lat_e4_upd", 32'(upd), 32'h1);
            if (k == 6) chk("lat_e5_upd", 32'(upd), 32'h0);
        end

        // Toggling faster than the window never commits
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            bcd = (k % 4 < 2) ? 8'h12 : 8'h13;
            step();
            if (upd) pulses++;
        end
        chk("toggle_no_commit", 32'(pulses), 32'd0);
        bcd = 8'h42;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (upd) pulses++;
            if (k == 4) chk("hold42_e3", 32'(upd), 32'h0);
            if (k == 5) chk("hold42_e4", 32'(upd), 32'h1);
        end
        chk("hold42_single_pulse", 32'(pulses), 32'd1);

        // Table: commit a value, then observe both digits over two full frames
        foreach (tbl[r]) begin
            bcd = tbl[r].bcd;
            blank = tbl[r].blank;
            pulses = 0;
            bad_en = 0;
            s0 = 8'hFF;
            s1 = 8'hFF;
            for (int k = 0; k < 40; k++) begin
                step();
                if (upd) pulses++;
                if (en == 2'b10) begin
                    if (k >= 8) s0 = {1'b0, seg};
                end else if (en == 2'b01) begin
                    if (k >= 8) s1 = {1'b0, seg};
                end else begin
                    bad_en++;
                end
            end
            chk($sformatf("vec%0d_pulses", r), 32'(pulses), 32'(tbl[r].pulses));
            chk($sformatf("vec%0d_seg0", r), 32'(s0), 32'(tbl[r].s0));
            chk($sformatf("vec%0d_seg1", r), 32'(s1), 32'(tbl[r].s1));
            chk($sformatf("vec%0d_en_onehot", r), 32'(bad_en), 32'd0);
        end

        // Async reset mid-slot with a partial window in flight
        blank = 1'b0;
        bcd = 8'h57;
        repeat (10) step();
        bcd = 8'h33;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_en", 32'(en), 32'h3);
        chk("midrst_upd", 32'(upd), 32'h0);
        bcd = 8'h57;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 4) chk("recommit_e3", 32'(upd), 32'h0);
            if (k == 5) chk("recommit_e4", 32'(upd), 32'h1);
            if (k == 7) chk("recommit_seg0", 32'(seg), 32'b0001111);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Downstream consumer of the binary-to-BCD converter's packed BCD output. It filters out the intermediate values the converter emits while a conversion is in progress by committing a value only after it has been stable for a programmable number of cycles. It then time-multiplexes the committed digits onto one active-low seven-segment bus with per-digit enables, applying optional leading-zero blanking. It sits between the converter and the board's display pins.

## Interface
- DECIMAL_DIGITS, 2: number of BCD digits consumed and scanned (≥1)
- STABLE_CYCLES, 16: consecutive equal-input edges required before a value is committed (≥1)
- SCAN_CYCLES, 25000: clock cycles each digit stays enabled per scan slot (≥2)
- i_Clock  in  1  system clock, all state on rising edge
- i_Rst_L  in  1  asynchronous, active-low reset
- i_BCD  in  DECIMAL_DIGITS*4  packed BCD, digit 0 (units) in [3:0]
- i_Blank_Zeros  in  1  1 = blank leading zero digits
- o_Segment  out  7  active-low segments, bit6=A … bit0=G
- o_Digit_En  out  DECIMAL_DIGITS  active-low one-hot digit enable
- o_Updated  out  1  one-cycle pulse when committed value changes

## Operation
- Stability filter: candidate register C, counter N (saturates at STABLE_CYCLES), committed register D.
  - Edge with i_BCD != C: C <= i_BCD, N <= 0.
  - Edge with i_BCD == C and N < STABLE_CYCLES: N <= N+1; if N == STABLE_CYCLES-1 and C != D, then D <= C and o_Updated <= 1.
  - o_Updated is 0 on every other edge; recommitting an equal value produces no pulse.
- Scan: slot counter S counts 0..SCAN_CYCLES-1 and wraps; on wrap, digit index K advances 0→1→…→DECIMAL_DIGITS-1→0.
- Decode (registered) of D digit K, 7-bit A..G, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - codes 10–15 = dash 1111110
- Blanking: digit K>0 outputs 1111111 when i_Blank_Zeros=1 and digits K..DECIMAL_DIGITS-1 of D are all 0. Digit 0 is never blanked.
- i_Blank_Zeros is sampled live each edge; there is no filtering.

## Timing
- Reset (async assert, any time including mid-scan or mid-filter): C=0, D=0, N=0, S=0, K=0, o_Segment=1111111, o_Digit_En=all 1, o_Updated=0.
- On the first edge after deassert, o_Digit_En = ~1 (digit 0) and o_Segment = decode of D digit 0 (0000001).
- o_Segment and o_Digit_En are registered and update on the same edge; there is no skew between digit select and its segments.
- Commit latency: new value first sampled at edge E; D and o_Updated update at edge E+STABLE_CYCLES. The display reflects the value from edge E+STABLE_CYCLES+1 onward for the active digit.
- Any input change inside the window restarts the window, so a value toggling faster than STABLE_CYCLES never commits.
- Simultaneous commit and slot wrap: the new digit slot decodes the new D on the following edge. Mixed old/new within one slot change is acceptable for exactly one cycle.
- Each digit is enabled for exactly SCAN_CYCLES cycles per slot; one frame = DECIMAL_DIGITS*SCAN_CYCLES cycles.
- With DECIMAL_DIGITS=1, o_Digit_En stays 0 permanently after reset.

## Test plan
- Reset then i_BCD=0x00, i_Blank_Zeros=0, STABLE_CYCLES=4, SCAN_CYCLES=8 -> o_Updated never pulses; digit0 and digit1 both show 0000001, each enable low for 8 cycles, alternating.
- i_BCD 0x00→0x57 at edge 10, held -> D=0x57 and o_Updated=1 after edge 14 only. Digit0 shows 0001111 (7), digit1 shows 0100100 (5).
- i_BCD toggles 0x12/0x13 every 2 cycles for 40 cycles, then holds 0x42 -> no commit during toggling; D=0x42 exactly 4 edges after the hold starts, with a single pulse.
- i_BCD=0x05 committed, i_Blank_Zeros=1 -> digit1 slot outputs 1111111 and digit0 outputs 0100100. With i_Blank_Zeros=0, digit1 shows 0000001.
- i_BCD=0xA3 held -> digit1 shows dash 1111110 and digit0 shows 0000110.
- Assert i_Rst_L low mid-slot with D=0x57 and N=2 -> outputs go 1111111 / all-1 / 0 immediately without a clock edge. After release, 0x57 re-commits 4 edges after its first sample.
